redirect_source_arbiter: RTL and testbench

- Transmit side of the IF-stage redirect interface. Consumes raw redirect requests from EX (branch), the trap unit (trap, mret) and the BTB (prediction).
- Emits at most one redirect per non-stalled cycle on the trap/mret/branch/prediction signals consumed by the control flow tracker and the PC controller.
- Latches non-prediction redirects that arrive during a stall and replays them on the first non-stalled cycle. Maintains a fetch epoch counter for tagging in-flight fetches.

---
 rtl/redirect_pkg.sv | 24 ++
 rtl/redirect_priority_sel.sv | 47 ++++
 rtl/redirect_source_arbiter.sv | 99 +++++++++
 tb/tb_redirect_source_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/redirect_pkg.sv
// Shared types and helpers for the IF-stage redirect source arbiter.
// Source encoding is ordered so that numeric compare gives priority.
package redirect_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_MRET   = 2'd2,
    SRC_TRAP   = 2'd3
  } redirect_src_e;

  // Conditions the two low bits of a target; upper bits pass through.
  function automatic logic [1:0] align_target(
    input logic [1:0] target,
    input logic       c_ext
  );
    logic [1:0] t;
    t    = target;
    t[0] = 1'b0;
    if (!c_ext) t[1] = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/redirect_priority_sel.sv
// Picks the winning redirect class and target from live requests
// and the pending entry; a live request wins ties.
module redirect_priority_sel
  import redirect_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_trap_req,
  input  logic              i_mret_req,
  input  logic              i_branch_req,
  input  logic [XLEN-1:0]   i_trap_target,
  input  logic [XLEN-1:0]   i_mepc,
  input  logic [XLEN-1:0]   i_branch_target,
  input  redirect_src_e     i_pend_src,
  input  logic [XLEN-1:0]   i_pend_target,
  output redirect_src_e     o_src,
  output logic [XLEN-1:0]   o_target
);

  redirect_src_e   w_live_src;
  logic [XLEN-1:0] w_live_tgt;

  always_comb begin
    w_live_src = SRC_NONE;
    w_live_tgt = i_branch_target;
    if (i_trap_req) begin
      w_live_src = SRC_TRAP;
      w_live_tgt = i_trap_target;
    end else if (i_mret_req) begin
      w_live_src = SRC_MRET;
      w_live_tgt = i_mepc;
    end else if (i_branch_req) begin
      w_live_src = SRC_BRANCH;
      w_live_tgt = i_branch_target;
    end
  end

  always_comb begin
    o_src    = i_pend_src;
    o_target = i_pend_target;
    if (w_live_src != SRC_NONE && w_live_src >= i_pend_src) begin
      o_src    = w_live_src;
      o_target = w_live_tgt;
    end
  end

endmodule

// File: rtl/redirect_source_arbiter.sv
// IF-stage redirect transmit side: arbitrates trap/mret/branch/prediction,
// replays redirects latched during a stall and tracks the fetch epoch.
module redirect_source_arbiter
  import redirect_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EPOCH_W = 3,
  parameter bit C_EXT   = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_stall,
  input  logic               i_trap_req,
  input  logic               i_mret_req,
  input  logic [XLEN-1:0]    i_trap_target,
  input  logic [XLEN-1:0]    i_mepc,
  input  logic               i_branch_req,
  input  logic [XLEN-1:0]    i_branch_target,
  input  logic               i_pred_req,
  input  logic [XLEN-1:0]    i_pred_target,
  output logic               o_trap_taken,
  output logic               o_mret_taken,
  output logic               o_branch_taken,
  output logic               o_prediction_used,
  output logic [XLEN-1:0]    o_trap_target,
  output logic [XLEN-1:0]    o_branch_target,
  output logic [XLEN-1:0]    o_predicted_target,
  output logic               o_flush,
  output logic               o_redirect_pending,
  output logic [EPOCH_W-1:0] o_epoch
);

  redirect_src_e      r_pend_src;
  logic [XLEN-1:0]    r_pend_tgt;
  logic [EPOCH_W-1:0] r_epoch;

  redirect_src_e   w_win_src;
  logic [XLEN-1:0] w_win_tgt;
  logic [XLEN-1:0] w_al_win;
  logic [XLEN-1:0] w_al_pred;
  logic            w_active;
  logic            w_issue;
  logic            w_pred_issue;
  logic            w_trap;
  logic            w_mret;

  // The same selection drives issue and the stall-time capture.
  redirect_priority_sel #(
    .XLEN(XLEN)
  ) u_sel (
    .i_trap_req     (i_trap_req),
    .i_mret_req     (i_mret_req),
    .i_branch_req   (i_branch_req),
    .i_trap_target  (i_trap_target),
    .i_mepc         (i_mepc),
    .i_branch_target(i_branch_target),
    .i_pend_src     (r_pend_src),
    .i_pend_target  (r_pend_tgt),
    .o_src          (w_win_src),
    .o_target       (w_win_tgt)
  );

  assign w_active     = i_reset_n & ~i_stall;
  assign w_issue      = w_active & (w_win_src != SRC_NONE);
  assign w_pred_issue = w_active & (w_win_src == SRC_NONE) & i_pred_req;
  assign w_trap       = w_issue & (w_win_src == SRC_TRAP);
  assign w_mret       = w_issue & (w_win_src == SRC_MRET);

  assign w_al_win  = {w_win_tgt[XLEN-1:2],
                      align_target(w_win_tgt[1:0], C_EXT)};
  assign w_al_pred = {i_pred_target[XLEN-1:2],
                      align_target(i_pred_target[1:0], C_EXT)};

  assign o_trap_taken       = w_trap;
  assign o_mret_taken       = w_mret;
  assign o_branch_taken     = w_issue & (w_win_src == SRC_BRANCH);
  assign o_prediction_used  = w_pred_issue;
  assign o_flush            = w_issue;
  assign o_trap_target      = (w_trap | w_mret) ? w_al_win : '0;
  assign o_branch_target    = o_branch_taken ? w_al_win : '0;
  assign o_predicted_target = w_pred_issue ? w_al_pred : '0;
  assign o_redirect_pending = (r_pend_src != SRC_NONE);
  assign o_epoch            = r_epoch;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pend_src <= SRC_NONE;
      r_pend_tgt <= '0;
      r_epoch    <= '0;
    end else if (i_stall) begin
      r_pend_src <= w_win_src;
      r_pend_tgt <= w_win_tgt;
    end else begin
      r_pend_src <= SRC_NONE;
      if (w_issue | w_pred_issue) r_epoch <= r_epoch + 1'b1;
    end
  end

endmodule

// File: tb/tb_redirect_source_arbiter.sv
// Scoreboard bench for redirect_source_arbiter, checking C_EXT=1 and
// C_EXT=0 instances against a class/priority reference model.
module tb_redirect_source_arbiter;

  typedef struct packed {
    logic [3:0]  taken;
    logic        flush;
    logic        pend;
    logic [2:0]  epoch;
    logic [31:0] tt;
    logic [31:0] bt;
    logic [31:0] pt;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, trap, mret, br, pred;
  logic [31:0] tt, mepc, bt, pt;

  logic        a_tr, a_mr, a_br, a_pr, a_fl, a_pe;
  logic [31:0] a_tt, a_bt, a_pt;
  logic [2:0]  a_ep;
  logic        b_tr, b_mr, b_br, b_pr, b_fl, b_pe;
  logic [31:0] b_tt, b_bt, b_pt;
  logic [2:0]  b_ep;

  out_t q1[$];
  out_t q0[$];
  int   tests = 0;
  int   fails = 0;

  int          m_cls = 0;
  logic [31:0] m_tgt = '0;
  int          m_epoch = 0;

  always #5 clk = ~clk;

  redirect_source_arbiter #(.XLEN(32), .EPOCH_W(3), .C_EXT(1'b1)) u_c1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_stall(stall),
    .i_trap_req(trap), .i_mret_req(mret),
    .i_trap_target(tt), .i_mepc(mepc),
    .i_branch_req(br), .i_branch_target(bt),
    .i_pred_req(pred), .i_pred_target(pt),
    .o_trap_taken(a_tr), .o_mret_taken(a_mr),
    .o_branch_taken(a_br), .o_prediction_used(a_pr),
    .o_trap_target(a_tt), .o_branch_target(a_bt),
    .o_predicted_target(a_pt), .o_flush(a_fl),
    .o_redirect_pending(a_pe), .o_epoch(a_ep)
  );

  redirect_source_arbiter #(.XLEN(32), .EPOCH_W(3), .C_EXT(1'b0)) u_c0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_stall(stall),
    .i_trap_req(trap), .i_mret_req(mret),
    .i_trap_target(tt), .i_mepc(mepc),
    .i_branch_req(br), .i_branch_target(bt),
    .i_pred_req(pred), .i_pred_target(pt),
    .o_trap_taken(b_tr), .o_mret_taken(b_mr),
    .o_branch_taken(b_br), .o_prediction_used(b_pr),
    .o_trap_target(b_tt), .o_branch_target(b_bt),
    .o_predicted_target(b_pt), .o_flush(b_fl),
    .o_redirect_pending(b_pe), .o_epoch(b_ep)
  );

  function automatic logic [31:0] al(input logic [31:0] t, input bit c);
    return c ? (t & 32'hFFFF_FFFE) : (t & 32'hFFFF_FFFC);
  endfunction

  // Reference: classes 3=trap 2=mret 1=branch 0=none.
  task automatic model_push();
    int          live;
    logic [31:0] ltgt;
    int          wcls;
    logic [31:0] wtgt;
    out_t        e1, e0;
    live = trap ? 3 : mret ? 2 : br ? 1 : 0;
    ltgt = trap ? tt : mret ? mepc : bt;
    if (live != 0 && live >= m_cls) begin
      wcls = live; wtgt = ltgt;
    end else begin
      wcls = m_cls; wtgt = m_tgt;
    end
    e1 = '0;
    e1.pend  = (m_cls != 0);
    e1.epoch = 3'(m_epoch);
    e0 = e1;
    if (!rst_n) begin
      m_cls = 0; m_tgt = '0; m_epoch = 0;
    end else if (stall) begin
      m_cls = wcls; m_tgt = wtgt;
    end else if (wcls != 0) begin
      e1.flush = 1'b1; e0.flush = 1'b1;
      e1.taken = 4'b1 << wcls; e0.taken = 4'b1 << wcls;
      if (wcls == 1) begin
        e1.bt = al(wtgt, 1); e0.bt = al(wtgt, 0);
      end else begin
        e1.tt = al(wtgt, 1); e0.tt = al(wtgt, 0);
      end
      m_cls = 0;
      m_epoch = (m_epoch + 1) % 8;
    end else if (pred) begin
      e1.taken = 4'b0001; e0.taken = 4'b0001;
      e1.pt = al(pt, 1); e0.pt = al(pt, 0);
      m_epoch = (m_epoch + 1) % 8;
    end
    q1.push_back(e1);
    q0.push_back(e0);
  endtask

  task automatic cyc(input logic r, input logic s, input logic t_, input logic m_,
                     input logic b_, input logic p_, input logic [31:0] tt_,
                     input logic [31:0] me_, input logic [31:0] bt_,
                     input logic [31:0] pt_);
    @(posedge clk); #1;
    rst_n = r; stall = s; trap = t_; mret = m_; br = b_; pred = p_;
    tt = tt_; mepc = me_; bt = bt_; pt = pt_;
    model_push();
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string nm, input out_t got, input out_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h required=%h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    out_t g1, g0;
    g1 = {a_tr, a_mr, a_br, a_pr, a_fl, a_pe, a_ep, a_tt, a_bt, a_pt};
    g0 = {b_tr, b_mr, b_br, b_pr, b_fl, b_pe, b_ep, b_tt, b_bt, b_pt};
    if (q1.size() > 0) check("cext1", g1, q1.pop_front());
    if (q0.size() > 0) check("cext0", g0, q0.pop_front());
  end

  initial begin
    rst_n = 0; stall = 0; trap = 0; mret = 0; br = 0; pred = 0;
    tt = '0; mepc = '0; bt = '0; pt = '0;
    cyc(0, 0, 1, 1, 1, 1, 32'h55, 32'h66, 32'h77, 32'h88);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Zero-latency branch.
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 32'h0000_1006, 0);
    idle();
    // Branch latched during stall, replayed after.
    cyc(1, 1, 0, 0, 1, 1, 0, 0, 32'h0000_2000, 32'h9);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 32'h44);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h48);
    idle();
    // Trap overwrites pending branch.
    cyc(1, 1, 0, 0, 1, 0, 0, 0, 32'h0000_2000, 0);
    cyc(1, 1, 1, 0, 0, 0, 32'h0000_0100, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0, 0, 32'h0000_2222, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Mret beats prediction; prediction alone.
    cyc(1, 0, 0, 1, 0, 1, 0, 32'h0000_4001, 0, 32'h0000_3002);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0000_3002);
    // Epoch wrap over 8 branches from reset.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 1, 0, 0, 0, 32'h100 + i * 4, 0);
    // Reset discards a pending trap.
    cyc(1, 1, 1, 0, 0, 0, 32'h0000_0200, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // Pending replay racing a losing live request.
    cyc(1, 1, 0, 1, 0, 0, 0, 32'h0000_0777, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 32'h0000_0999, 32'h5);
    idle();
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
          $urandom(), $urandom(), $urandom(), $urandom());
    end
    idle();
    repeat (3) @(posedge clk);
    tests++;
    if (q1.size() != 0 || q0.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d/%0d required=0/0", q1.size(), q0.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
